// File: rtl/hwpe_ctrl_uloop_nest_pkg.sv
// Shared types and defaults for the nested-loop microcode engine.
// Provides the microcode op encoding, the microcode word layout, the
// engine state encoding and default sizing parameters.
package hwpe_ctrl_uloop_nest_pkg;

  localparam int unsigned ULOOP_NEST_NB_LOOPS  = 4;
  localparam int unsigned ULOOP_NEST_LENGTH    = 16;
  localparam int unsigned ULOOP_NEST_NB_REG    = 4;
  localparam int unsigned ULOOP_NEST_NB_RO_REG = 8;
  localparam int unsigned ULOOP_NEST_REG_WIDTH = 32;
  localparam int unsigned ULOOP_NEST_CNT_WIDTH = 16;

  // Operand index spans the whole visible register space {ro, rw}
  localparam int unsigned ULOOP_OPND_WIDTH = $clog2(ULOOP_NEST_NB_REG + ULOOP_NEST_NB_RO_REG);

  typedef enum logic [1:0] {
    ULOOP_NOP = 2'b00,
    ULOOP_MOV = 2'b01,
    ULOOP_ADD = 2'b10,
    ULOOP_SUB = 2'b11
  } uloop_op_t;

  typedef struct packed {
    uloop_op_t                   op;
    logic [ULOOP_OPND_WIDTH-1:0] a;
    logic [ULOOP_OPND_WIDTH-1:0] b;
  } uloop_code_t;

  typedef enum logic [1:0] {
    ULN_IDLE,
    ULN_EMIT,
    ULN_EXEC,
    ULN_DONE
  } uloop_nest_state_t;

  // Bit width able to index n items, never below one bit
  function automatic int unsigned uloop_clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_uloop_lvl_sel.sv
// Loop level selector (combinational).
// Ports:
//   idx  - current loop indices, level 0 innermost
//   rng  - iterations per level (0 behaves as 1)
//   lvl  - lowest level whose index can still be incremented
//   last - every level sits at its final index
module hwpe_ctrl_uloop_lvl_sel
  import hwpe_ctrl_uloop_nest_pkg::*;
#(
  parameter int unsigned NB_LOOPS  = ULOOP_NEST_NB_LOOPS,
  parameter int unsigned CNT_WIDTH = ULOOP_NEST_CNT_WIDTH,
  parameter int unsigned LVL_WIDTH = uloop_clog2_min1(NB_LOOPS)
) (
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx,
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] rng,
  output logic [LVL_WIDTH-1:0]               lvl,
  output logic                               last
);

  logic [NB_LOOPS-1:0] at_top;

  // A level is saturated at index max(rng,1)-1; a zero range is always saturated
  always_comb begin
    at_top = '0;
    for (int j = 0; j < int'(NB_LOOPS); j++) begin
      at_top[j] = (rng[j] == '0) || (idx[j] >= rng[j] - CNT_WIDTH'(1));
    end
  end

  // Scan from the outermost level down so the lowest free level wins
  always_comb begin
    lvl = '0;
    for (int j = int'(NB_LOOPS) - 1; j >= 0; j--) begin
      if (!at_top[j]) lvl = LVL_WIDTH'(j);
    end
  end

  assign last = &at_top;

endmodule

// File: rtl/hwpe_ctrl_uloop_nest.sv
// Nested-loop microcode engine for streamer address generation.
// Walks NB_LOOPS loops in odometer order (loop 0 innermost); on every index
// update it runs that loop's microcode slice over a private register file,
// then presents one {idx, offs} beat on a valid/ready handshake.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   test_mode_i          - no functional effect
//   clear_i              - synchronous abort, highest priority
//   start_i              - start pulse, honoured only when idle
//   range_i              - iterations per loop (0 treated as 1)
//   loop_addr_i          - first microcode word of each loop
//   loop_nbops_i         - number of ops per loop (0 allowed)
//   code_i               - microcode store
//   registers_read_i     - read-only operand registers
//   valid_o / ready_i    - beat handshake
//   idx_o / offs_o       - current loop indices / offset registers
//   busy_o               - engine not idle
//   done_o               - one-cycle pulse after the last beat is accepted
module hwpe_ctrl_uloop_nest
  import hwpe_ctrl_uloop_nest_pkg::*;
#(
  parameter int unsigned NB_LOOPS  = ULOOP_NEST_NB_LOOPS,
  parameter int unsigned LENGTH    = ULOOP_NEST_LENGTH,
  parameter int unsigned NB_REG    = ULOOP_NEST_NB_REG,
  parameter int unsigned NB_RO_REG = ULOOP_NEST_NB_RO_REG,
  parameter int unsigned REG_WIDTH = ULOOP_NEST_REG_WIDTH,
  parameter int unsigned CNT_WIDTH = ULOOP_NEST_CNT_WIDTH
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        test_mode_i,
  input  logic                                        clear_i,
  input  logic                                        start_i,
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]          range_i,
  input  logic [NB_LOOPS-1:0][$clog2(LENGTH)-1:0]     loop_addr_i,
  input  logic [NB_LOOPS-1:0][$clog2(LENGTH):0]       loop_nbops_i,
  input  uloop_code_t [LENGTH-1:0]                    code_i,
  input  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]         registers_read_i,
  output logic                                        valid_o,
  input  logic                                        ready_i,
  output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]          idx_o,
  output logic [NB_REG-1:0][REG_WIDTH-1:0]            offs_o,
  output logic                                        busy_o,
  output logic                                        done_o
);

  localparam int unsigned PC_WIDTH  = $clog2(LENGTH);
  localparam int unsigned OPS_WIDTH = PC_WIDTH + 1;
  localparam int unsigned LVL_WIDTH = uloop_clog2_min1(NB_LOOPS);

  uloop_nest_state_t                  state_q;
  logic [PC_WIDTH-1:0]                pc_q;
  logic [OPS_WIDTH-1:0]               opcnt_q;

  logic [LVL_WIDTH-1:0]               lvl;
  logic                               last;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_nxt;
  logic [PC_WIDTH-1:0]                pc_inc;

  uloop_code_t                        cur;
  logic [REG_WIDTH-1:0]               opnd_a;
  logic [REG_WIDTH-1:0]               opnd_b;
  logic [REG_WIDTH-1:0]               wr_data;
  logic                               wr_en;

  logic                               unused_test_mode;
  assign unused_test_mode = test_mode_i;

  hwpe_ctrl_uloop_lvl_sel #(
    .NB_LOOPS  ( NB_LOOPS  ),
    .CNT_WIDTH ( CNT_WIDTH ),
    .LVL_WIDTH ( LVL_WIDTH )
  ) i_lvl_sel (
    .idx  ( idx_o   ),
    .rng  ( range_i ),
    .lvl  ( lvl     ),
    .last ( last    )
  );

  // Odometer step: bump the selected level, reset every inner level
  always_comb begin
    idx_nxt = idx_o;
    for (int j = 0; j < int'(NB_LOOPS); j++) begin
      if (j < int'(lvl)) begin
        idx_nxt[j] = '0;
      end else if (j == int'(lvl)) begin
        idx_nxt[j] = idx_o[j] + CNT_WIDTH'(1);
      end
    end
  end

  assign pc_inc = (pc_q == PC_WIDTH'(LENGTH - 1)) ? '0 : pc_q + PC_WIDTH'(1);
  assign cur    = code_i[pc_q];

  // Operand fetch: writable regs occupy indices 0..NB_REG-1, read-only above
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    for (int i = 0; i < int'(NB_REG); i++) begin
      if (int'(cur.a) == i) opnd_a = offs_o[i];
      if (int'(cur.b) == i) opnd_b = offs_o[i];
    end
    for (int i = 0; i < int'(NB_RO_REG); i++) begin
      if (int'(cur.b) == i + int'(NB_REG)) opnd_b = registers_read_i[i];
    end
  end

  // ALU; destinations outside the writable file are silently dropped
  always_comb begin
    wr_data = opnd_a;
    wr_en   = (cur.op != ULOOP_NOP) && (int'(cur.a) < int'(NB_REG));
    case (cur.op)
      ULOOP_MOV: wr_data = opnd_b;
      ULOOP_ADD: wr_data = opnd_a + opnd_b;
      ULOOP_SUB: wr_data = opnd_a - opnd_b;
      default:   wr_data = opnd_a;
    endcase
  end

  // Sequencer with registered handshake/status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ULN_IDLE;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      idx_o   <= '0;
      offs_o  <= '0;
      pc_q    <= '0;
      opcnt_q <= '0;
    end else if (clear_i) begin
      state_q <= ULN_IDLE;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      idx_o   <= '0;
      offs_o  <= '0;
      pc_q    <= '0;
      opcnt_q <= '0;
    end else begin
      case (state_q)
        ULN_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            idx_o   <= '0;
            offs_o  <= '0;
            pc_q    <= '0;
            opcnt_q <= '0;
            state_q <= ULN_EMIT;
            valid_o <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        ULN_EMIT: begin
          if (ready_i) begin
            if (last) begin
              state_q <= ULN_DONE;
              valid_o <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              idx_o   <= idx_nxt;
              pc_q    <= loop_addr_i[lvl];
              opcnt_q <= loop_nbops_i[lvl];
              // A loop without ops chains straight into the next beat
              if (loop_nbops_i[lvl] != '0) begin
                state_q <= ULN_EXEC;
                valid_o <= 1'b0;
              end
            end
          end
        end
        ULN_EXEC: begin
          for (int i = 0; i < int'(NB_REG); i++) begin
            if (wr_en && (int'(cur.a) == i)) offs_o[i] <= wr_data;
          end
          pc_q    <= pc_inc;
          opcnt_q <= opcnt_q - OPS_WIDTH'(1);
          if (opcnt_q <= OPS_WIDTH'(1)) begin
            state_q <= ULN_EMIT;
            valid_o <= 1'b1;
          end
        end
        ULN_DONE: begin
          state_q <= ULN_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= ULN_IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
